// File: rtl/rv32i_pkg.sv
// rv32i_pkg: constants and types shared by the RV32I instruction-fetch front end.
//   INST_BUBBLE : instruction word presented to decode when nothing is valid
//   PC_STEP     : byte distance between consecutive sequential fetches
//   pf_state_e  : prefetch request FSM states
package rv32i_pkg;

  localparam logic [31:0] INST_BUBBLE = 32'h0000_0000;
  localparam int unsigned PC_STEP     = 4;

  typedef enum logic [1:0] {
    PF_IDLE    = 2'd0,
    PF_WAIT    = 2'd1,
    PF_DISCARD = 2'd2
  } pf_state_e;

endpackage

// File: rtl/pf_fifo.sv
// pf_fifo: synchronous FIFO of {PC, instruction} pairs for the prefetch queue.
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   i_flush       : empty the FIFO (wins over push and pop)
//   i_push        : write {i_push_pc, i_push_inst} at the tail (ignored when full)
//   i_pop         : drop the head entry (ignored when empty)
//   o_count       : number of occupied entries, 0..DEPTH
//   o_head_pc     : PC of the head entry (undefined when empty)
//   o_head_inst   : instruction of the head entry (undefined when empty)
module pf_fifo
  import rv32i_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_flush,
  input  logic                          i_push,
  input  logic [DATA_WIDTH-1:0]         i_push_pc,
  input  logic [DATA_WIDTH-1:0]         i_push_inst,
  input  logic                          i_pop,
  output logic [$clog2(DEPTH):0]        o_count,
  output logic [DATA_WIDTH-1:0]         o_head_pc,
  output logic [DATA_WIDTH-1:0]         o_head_inst
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_WIDTH-1:0] r_pc   [DEPTH];
  logic [DATA_WIDTH-1:0] r_inst [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign w_do_push = i_push && !i_flush && (r_count != CW'(DEPTH));
  assign w_do_pop  = i_pop  && !i_flush && (r_count != '0);

  // Pointers wrap by natural overflow since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_do_push && w_do_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_pc[r_wr_ptr]   <= i_push_pc;
      r_inst[r_wr_ptr] <= i_push_inst;
    end
  end

  assign o_count     = r_count;
  assign o_head_pc   = r_pc[r_rd_ptr];
  assign o_head_inst = r_inst[r_rd_ptr];

endmodule

// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: instruction-fetch front end for the RV32I 5-stage pipeline.
// Issues one word fetch at a time over a request-held req/ack handshake, buffers
// returned (PC, instruction) pairs in pf_fifo and presents the head to decode.
// A redirect from EX flushes buffered entries and discards any in-flight fetch.
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   i_redirect      : taken branch / jump from EX
//   i_redirect_pc   : redirect target (low two bits ignored)
//   o_imem_req      : fetch request, held until i_imem_ack
//   o_imem_addr     : word-aligned fetch address, stable while requesting
//   i_imem_ack      : response valid, completes the request
//   i_imem_rdata    : fetched instruction
//   o_valid         : head entry available to decode
//   o_PC, o_Inst    : head PC / instruction (zero bubble when not valid)
//   i_ready         : decode accepts the head
// Optional build macro PREFETCH_BYPASS_EN: with an empty FIFO, an accepted ack
// is forwarded combinationally to decode, and not buffered if decode takes it.
module if_prefetch_queue
  import rv32i_pkg::*;
#(
  parameter int unsigned              DATA_WIDTH = 32,
  parameter int unsigned              DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0]    RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_redirect,
  input  logic [DATA_WIDTH-1:0] i_redirect_pc,
  output logic                  o_imem_req,
  output logic [DATA_WIDTH-1:0] o_imem_addr,
  input  logic                  i_imem_ack,
  input  logic [DATA_WIDTH-1:0] i_imem_rdata,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_PC,
  output logic [DATA_WIDTH-1:0] o_Inst,
  input  logic                  i_ready
);

  localparam int unsigned           CW         = $clog2(DEPTH) + 1;
  localparam logic [DATA_WIDTH-1:0] W_STEP     = DATA_WIDTH'(PC_STEP);
  localparam logic [DATA_WIDTH-1:0] W_BUBBLE   = DATA_WIDTH'(INST_BUBBLE);
  localparam logic [DATA_WIDTH-1:0] W_ALIGN    = ~DATA_WIDTH'(3);
  localparam logic [DATA_WIDTH-1:0] W_RESET_PC = RESET_PC & W_ALIGN;

  pf_state_e             r_state;
  pf_state_e             w_state_nxt;
  logic [DATA_WIDTH-1:0] r_fetch_pc;
  logic [DATA_WIDTH-1:0] r_req_addr;
  logic [DATA_WIDTH-1:0] w_redirect_pc;
  logic [CW-1:0]         w_count;
  logic [DATA_WIDTH-1:0] w_head_pc;
  logic [DATA_WIDTH-1:0] w_head_inst;
  logic                  w_fifo_empty;
  logic                  w_fifo_full;
  logic                  w_issue;
  logic                  w_ack_accept;
  logic                  w_push;
  logic                  w_pop;

  assign w_redirect_pc = i_redirect_pc & W_ALIGN;
  assign w_fifo_empty  = (w_count == '0);
  assign w_fifo_full   = (w_count == CW'(DEPTH));

  // A new request is only launched from IDLE, which is never entered in the
  // same cycle as an ack, so back-to-back requests are at least 2 cycles apart.
  assign w_issue       = (r_state == PF_IDLE) && !w_fifo_full && !i_redirect;
  assign w_ack_accept  = (r_state == PF_WAIT) && i_imem_ack && !i_redirect;

`ifdef PREFETCH_BYPASS_EN
  logic w_bypass;
  assign w_bypass = w_fifo_empty && w_ack_accept;
  assign w_push   = w_ack_accept && !(w_bypass && i_ready);
`else
  assign w_push   = w_ack_accept;
`endif

  // The FIFO flush has priority, so a pop in a redirect cycle is dropped there.
  assign w_pop = !w_fifo_empty && i_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= PF_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      PF_IDLE: begin
        if (w_issue) w_state_nxt = PF_WAIT;
      end
      PF_WAIT: begin
        if (i_imem_ack)      w_state_nxt = PF_IDLE;
        else if (i_redirect) w_state_nxt = PF_DISCARD;
      end
      PF_DISCARD: begin
        if (i_imem_ack) w_state_nxt = PF_IDLE;
      end
      default: w_state_nxt = PF_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_imem_req = (r_state != PF_IDLE);
    o_valid    = !w_fifo_empty;
    o_PC       = w_fifo_empty ? '0       : w_head_pc;
    o_Inst     = w_fifo_empty ? W_BUBBLE : w_head_inst;
`ifdef PREFETCH_BYPASS_EN
    if (w_bypass) begin
      o_valid = 1'b1;
      o_PC    = r_fetch_pc;
      o_Inst  = i_imem_rdata;
    end
`endif
  end

  assign o_imem_addr = r_req_addr;

  // fetch_pc only advances on an accepted ack; the issued address is latched
  // separately so a redirect in WAIT/DISCARD can retarget fetch_pc while the
  // stale request is still held on the bus with its original address.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= W_RESET_PC;
      r_req_addr <= W_RESET_PC;
    end else begin
      if (i_redirect) begin
        r_fetch_pc <= w_redirect_pc;
      end else if (w_ack_accept) begin
        r_fetch_pc <= r_fetch_pc + W_STEP;
      end
      if (w_issue) begin
        r_req_addr <= r_fetch_pc;
      end
    end
  end

  pf_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (i_redirect),
    .i_push      (w_push),
    .i_push_pc   (r_fetch_pc),
    .i_push_inst (i_imem_rdata),
    .i_pop       (w_pop),
    .o_count     (w_count),
    .o_head_pc   (w_head_pc),
    .o_head_inst (w_head_inst)
  );

endmodule
